// File: rtl/regfile_pkg.sv
// Shared definitions for the register file and its scoreboard.
//
// Contents:
//   DATA_WIDTH_DEF / ADDR_WIDTH_DEF : default register width and index width
//   ZERO_ADDR                       : index of the optional hardwired-zero register
//   reg_idx_t / reg_data_t          : register index and data types at default sizes
package regfile_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  localparam logic [ADDR_WIDTH_DEF-1:0] ZERO_ADDR = '0;

  typedef logic [ADDR_WIDTH_DEF-1:0] reg_idx_t;
  typedef logic [DATA_WIDTH_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write scoreboard.
//
// Tracks which registers have an issued but not yet written-back result,
// decides whether a new issue may be accepted, keeps a running count of
// pending registers and raises a sticky error on unexpected write-backs.
//
// Ports:
//   clk, reset     : rising-edge clock, asynchronous active-low reset
//   wb_en/wb_addr  : write-back enable and destination
//   issue_valid    : an instruction wants to issue, writing issue_dest
//   issue_dest     : destination index of the issuing instruction
//   flush          : drop every pending mark
//   busy           : one pending bit per register
//   issue_ready    : issue_dest may be claimed this cycle
//   pending_count  : number of set busy bits
//   error          : sticky, write-back to a register that was not pending
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_REGS   = 2**ADDR_WIDTH,
  parameter int ZERO_REG   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_dest,
  input  logic                  flush,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  issue_ready,
  output logic [ADDR_WIDTH:0]   pending_count,
  output logic                  error
);

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] idx);
    return (ZERO_REG != 0) && (idx == ADDR_WIDTH'(ZERO_ADDR));
  endfunction

  function automatic logic busy_of(input logic [ADDR_WIDTH-1:0] idx);
    return in_range(idx) ? busy[idx] : 1'b0;
  endfunction

  logic                  issue_set;
  logic                  wb_valid;
  logic                  wb_clear;
  logic                  wb_bad;
  logic [NUM_REGS-1:0]   busy_next;
  logic [ADDR_WIDTH:0]   count_next;

  // The zero register is never marked busy, so it is always ready.
  assign issue_ready = !flush && !busy_of(issue_dest);
  assign issue_set   = issue_valid && issue_ready && in_range(issue_dest) && !is_zero(issue_dest);

  assign wb_valid = wb_en && in_range(wb_addr) && !is_zero(wb_addr);
  assign wb_clear = wb_valid && busy_of(wb_addr);
  // Out-of-range targets and writes nobody was waiting for are both errors.
  assign wb_bad   = (wb_en && !in_range(wb_addr)) || (wb_valid && !busy_of(wb_addr));

  // Clear and set can never hit the same register in one cycle (clear needs
  // busy, set needs not busy), so applying set last is only a formality.
  always_comb begin
    busy_next  = busy;
    count_next = pending_count;
    if (flush) begin
      busy_next  = '0;
      count_next = '0;
    end else begin
      if (wb_clear) busy_next[wb_addr] = 1'b0;
      if (issue_set) busy_next[issue_dest] = 1'b1;
      case ({issue_set, wb_clear})
        2'b10:   count_next = pending_count + (ADDR_WIDTH+1)'(1);
        2'b01:   count_next = pending_count - (ADDR_WIDTH+1)'(1);
        default: count_next = pending_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy          <= '0;
      pending_count <= '0;
      error         <= 1'b0;
    end else begin
      busy          <= busy_next;
      pending_count <= count_next;
      if (wb_bad) error <= 1'b1;
    end
  end

endmodule

// File: rtl/register_file_scoreboard.sv
// Register file with two combinational read ports, one write-back port,
// optional hardwired-zero register, optional write-to-read bypass, and an
// attached pending-write scoreboard for issue control and hazard reporting.
//
// Ports:
//   clk, reset                          : clock, asynchronous active-low reset
//   Reg_Write_i / Write_Register_i / Write_Data_i : write-back port
//   Read_Register_x_i / Read_Data_x_o   : read ports 1 and 2
//   Busy_x_o                            : operand x still waits for a write-back
//   Issue_Valid_i / Issue_Dest_i        : issue request and its destination
//   Issue_Ready_o                       : issue accepted this cycle
//   Flush_i                             : clear all pending marks
//   Pending_Count_o                     : number of pending registers
//   Error_o                             : sticky unexpected write-back flag
module register_file_scoreboard
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int NUM_REGS   = 2**ADDR_WIDTH,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Reg_Write_i,
  input  logic [ADDR_WIDTH-1:0] Write_Register_i,
  input  logic [DATA_WIDTH-1:0] Write_Data_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
  input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
  output logic [DATA_WIDTH-1:0] Read_Data_1_o,
  output logic [DATA_WIDTH-1:0] Read_Data_2_o,
  output logic                  Busy_1_o,
  output logic                  Busy_2_o,
  input  logic                  Issue_Valid_i,
  input  logic [ADDR_WIDTH-1:0] Issue_Dest_i,
  output logic                  Issue_Ready_o,
  input  logic                  Flush_i,
  output logic [ADDR_WIDTH:0]   Pending_Count_o,
  output logic                  Error_o
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic                  write_commit;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] idx);
    return (ZERO_REG != 0) && (idx == ADDR_WIDTH'(ZERO_ADDR));
  endfunction

  function automatic logic forward_hit(input logic [ADDR_WIDTH-1:0] idx);
    return (BYPASS != 0) && Reg_Write_i && (Write_Register_i == idx);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] read_value(input logic [ADDR_WIDTH-1:0] idx);
    logic [DATA_WIDTH-1:0] value;
    value = '0;
    if (in_range(idx) && !is_zero(idx)) begin
      value = forward_hit(idx) ? Write_Data_i : regs[idx];
    end
    return value;
  endfunction

  // A forwarded write satisfies the operand this cycle, so it is not a hazard.
  function automatic logic busy_value(input logic [ADDR_WIDTH-1:0] idx);
    return in_range(idx) && busy[idx] && !forward_hit(idx);
  endfunction

  assign write_commit = Reg_Write_i && in_range(Write_Register_i) && !is_zero(Write_Register_i);

  // Storage array; reset wipes every entry, so an in-flight write is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (write_commit) begin
      regs[Write_Register_i] <= Write_Data_i;
    end
  end

  always_comb begin
    Read_Data_1_o = read_value(Read_Register_1_i);
    Read_Data_2_o = read_value(Read_Register_2_i);
    Busy_1_o      = busy_value(Read_Register_1_i);
    Busy_2_o      = busy_value(Read_Register_2_i);
  end

  regfile_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .ZERO_REG   (ZERO_REG)
  ) u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .wb_en         (Reg_Write_i),
    .wb_addr       (Write_Register_i),
    .issue_valid   (Issue_Valid_i),
    .issue_dest    (Issue_Dest_i),
    .flush         (Flush_i),
    .busy          (busy),
    .issue_ready   (Issue_Ready_o),
    .pending_count (Pending_Count_o),
    .error         (Error_o)
  );

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Self-checking bench for register_file_scoreboard at default parameters.
// A table of per-cycle vectors walks through write, bypass, zero register,
// issue blocking, overlapping issue/write-back and flush; hand-written
// sequences cover asynchronous reset mid-cycle and same-register
// issue plus write-back.
module tb_register_file_scoreboard;
  import regfile_pkg::*;

  logic        clk;
  logic        reset;
  logic        reg_write;
  reg_idx_t    write_register;
  reg_data_t   write_data;
  reg_idx_t    read_register_1;
  reg_idx_t    read_register_2;
  reg_data_t   read_data_1;
  reg_data_t   read_data_2;
  logic        busy_1;
  logic        busy_2;
  logic        issue_valid;
  reg_idx_t    issue_dest;
  logic        issue_ready;
  logic        flush;
  logic [5:0]  pending_count;
  logic        error;

  int checks;
  int failures;

  typedef struct {
    logic      we;
    reg_idx_t  wa;
    reg_data_t wd;
    reg_idx_t  r1;
    reg_idx_t  r2;
    logic      iv;
    reg_idx_t  id;
    logic      fl;
    reg_data_t d1;
    reg_data_t d2;
    logic      b1;
    logic      b2;
    logic      rdy;
    logic [5:0] cnt;
    logic      err;
  } vec_t;

  vec_t vecs [17];

  register_file_scoreboard dut (
    .clk               (clk),
    .reset             (reset),
    .Reg_Write_i       (reg_write),
    .Write_Register_i  (write_register),
    .Write_Data_i      (write_data),
    .Read_Register_1_i (read_register_1),
    .Read_Register_2_i (read_register_2),
    .Read_Data_1_o     (read_data_1),
    .Read_Data_2_o     (read_data_2),
    .Busy_1_o          (busy_1),
    .Busy_2_o          (busy_2),
    .Issue_Valid_i     (issue_valid),
    .Issue_Dest_i      (issue_dest),
    .Issue_Ready_o     (issue_ready),
    .Flush_i           (flush),
    .Pending_Count_o   (pending_count),
    .Error_o           (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mkVec(
    input logic we, input int wa, input int wd, input int r1, input int r2,
    input logic iv, input int id, input logic fl,
    input int d1, input int d2, input logic b1, input logic b2,
    input logic rdy, input int cnt, input logic err);
    vec_t v;
    v.we = we;  v.wa = reg_idx_t'(wa); v.wd = reg_data_t'(wd);
    v.r1 = reg_idx_t'(r1); v.r2 = reg_idx_t'(r2);
    v.iv = iv;  v.id = reg_idx_t'(id); v.fl = fl;
    v.d1 = reg_data_t'(d1); v.d2 = reg_data_t'(d2);
    v.b1 = b1;  v.b2 = b2; v.rdy = rdy;
    v.cnt = 6'(cnt); v.err = err;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reg_write       = v.we;
    write_register  = v.wa;
    write_data      = v.wd;
    read_register_1 = v.r1;
    read_register_2 = v.r2;
    issue_valid     = v.iv;
    issue_dest      = v.id;
    flush           = v.fl;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkVector(input int i, input vec_t v);
    checkOutput($sformatf("v%0d_rd1", i), read_data_1, v.d1);
    checkOutput($sformatf("v%0d_rd2", i), read_data_2, v.d2);
    checkOutput($sformatf("v%0d_busy1", i), 32'(busy_1), 32'(v.b1));
    checkOutput($sformatf("v%0d_busy2", i), 32'(busy_2), 32'(v.b2));
    checkOutput($sformatf("v%0d_ready", i), 32'(issue_ready), 32'(v.rdy));
    checkOutput($sformatf("v%0d_count", i), 32'(pending_count), 32'(v.cnt));
    checkOutput($sformatf("v%0d_error", i), 32'(error), 32'(v.err));
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Expected values are the combinational outputs before the vector's edge.
    //                 we wa wd  r1 r2 iv id fl   d1 d2 b1 b2 rdy cnt err
    vecs[0]  = mkVec(0, 0, 0,  1, 1, 1, 1, 0,   0, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mkVec(1, 1, 3,  1, 1, 0, 1, 0,   3, 3, 0, 0, 0, 1, 0);
    vecs[2]  = mkVec(0, 0, 0,  1, 1, 0, 0, 0,   3, 3, 0, 0, 1, 0, 0);
    vecs[3]  = mkVec(1, 0, 89, 0, 1, 1, 0, 0,   0, 3, 0, 0, 1, 0, 0);
    vecs[4]  = mkVec(0, 0, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
    vecs[5]  = mkVec(0, 0, 0,  7, 1, 1, 7, 0,   0, 3, 0, 0, 1, 0, 0);
    vecs[6]  = mkVec(0, 0, 0,  7, 7, 1, 7, 0,   0, 0, 1, 1, 0, 1, 0);
    vecs[7]  = mkVec(1, 7, 8,  7, 7, 0, 7, 0,   8, 8, 0, 0, 0, 1, 0);
    vecs[8]  = mkVec(0, 0, 0,  7, 1, 0, 7, 0,   8, 3, 0, 0, 1, 0, 0);
    vecs[9]  = mkVec(0, 0, 0, 17,25, 1,17, 0,   0, 0, 0, 0, 1, 0, 0);
    vecs[10] = mkVec(0, 0, 0, 17,25, 1,25, 0,   0, 0, 1, 0, 1, 1, 0);
    vecs[11] = mkVec(1,17, 5, 17,25, 1,30, 0,   5, 0, 0, 1, 1, 2, 0);
    vecs[12] = mkVec(0, 0, 0, 25,30, 1,17, 0,   0, 0, 1, 1, 1, 2, 0);
    vecs[13] = mkVec(0, 0, 0, 17,30, 1, 1, 1,   5, 0, 1, 1, 0, 3, 0);
    vecs[14] = mkVec(0, 0, 0,  1,17, 0, 1, 0,   3, 5, 0, 0, 1, 0, 0);
    vecs[15] = mkVec(1,17,45, 17,25, 0,17, 0,  45, 0, 0, 0, 1, 0, 0);
    vecs[16] = mkVec(0, 0, 0, 17, 7, 0, 0, 0,  45, 8, 0, 0, 1, 0, 1);

    reset = 1'b0;
    applyStimulus(mkVec(0, 0, 0, 1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    repeat (2) @(negedge clk);
    #2;
    checkOutput("reset_rd1", read_data_1, 32'd0);
    checkOutput("reset_rd2", read_data_2, 32'd0);
    checkOutput("reset_ready", 32'(issue_ready), 32'd1);
    checkOutput("reset_count", 32'(pending_count), 32'd0);
    checkOutput("reset_error", 32'(error), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #2;
      checkVector(i, vecs[i]);
    end

    // Asynchronous reset in the middle of a cycle with a write pending.
    @(negedge clk);
    applyStimulus(mkVec(0, 0, 0, 17, 7, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    issue_valid = 1'b0;
    #2;
    checkOutput("prerst_count", 32'(pending_count), 32'd1);
    checkOutput("prerst_rd1", read_data_1, 32'd45);
    reg_write      = 1'b1;
    write_register = reg_idx_t'(9);
    write_data     = reg_data_t'(77);
    #1 reset = 1'b0;
    #1;
    checkOutput("rst_count", 32'(pending_count), 32'd0);
    checkOutput("rst_error", 32'(error), 32'd0);
    checkOutput("rst_rd1", read_data_1, 32'd0);
    checkOutput("rst_rd2", read_data_2, 32'd0);
    @(negedge clk);
    reg_write = 1'b0;
    reset     = 1'b1;
    read_register_1 = reg_idx_t'(9);
    issue_dest      = reg_idx_t'(9);
    #2;
    checkOutput("rst_nocommit_rd1", read_data_1, 32'd0);
    checkOutput("rst_busy1", 32'(busy_1), 32'd0);
    checkOutput("rst_ready", 32'(issue_ready), 32'd1);

    // Issue and write-back on the same idle register in one cycle.
    @(negedge clk);
    applyStimulus(mkVec(1, 12, 4, 12, 9, 1, 12, 0, 0, 0, 0, 0, 0, 0, 0));
    #2;
    checkOutput("same_ready", 32'(issue_ready), 32'd1);
    checkOutput("same_rd1_bypass", read_data_1, 32'd4);
    checkOutput("same_error_pre", 32'(error), 32'd0);
    @(negedge clk);
    reg_write   = 1'b0;
    issue_valid = 1'b0;
    #2;
    checkOutput("same_busy1", 32'(busy_1), 32'd1);
    checkOutput("same_rd1", read_data_1, 32'd4);
    checkOutput("same_count", 32'(pending_count), 32'd1);
    checkOutput("same_error", 32'(error), 32'd1);
    checkOutput("same_ready_after", 32'(issue_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
